// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package serial_adder_pkg;

    localparam int unsigned SA_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Gate-level Half_Adder and the 1-bit full adder built from two of them plus an OR.
module Half_Adder (
    input  logic a,
    input  logic b,
    output logic S,
    output logic C
);
    assign S = a ^ b;
    assign C = a & b;
endmodule

module full_adder_1b (
    output logic S,
    output logic Co,
    input  logic a,
    input  logic b,
    input  logic ci
);
    logic s0, c0, c1;

    Half_Adder u_ha0 (.a(a),  .b(b),  .S(s0), .C(c0));
    Half_Adder u_ha1 (.a(s0), .b(ci), .S(S),  .C(c1));

    assign Co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// carry held in a flip-flop, result published with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, busy_q, done_q, cout_q;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_d;
    logic             unused_res_lsb;

    full_adder_1b u_fa (
        .S  (fa_s),
        .Co (fa_co),
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the first (LSB) sum bit.
    if (WIDTH == 1) begin : g_res_w1
        assign res_d = fa_s;
    end else begin : g_res_wn
        assign res_d = {fa_s, res_q[WIDTH-1:1]};
    end
    assign unused_res_lsb = res_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_co;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_co;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against a cycle-timeline model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_tot  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int dn8    = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: phase = edges since the accepting edge; -1 means idle.
    int         ph8 = -1, ph1 = -1;
    logic [8:0] pend8;
    logic [1:0] pend1;
    logic [7:0] ms8 = '0;
    logic       mc8 = 1'b0;
    logic [0:0] ms1 = '0;
    logic       mc1 = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph8 = -1; ms8 = '0; mc8 = 1'b0;
            ph1 = -1; ms1 = '0; mc1 = 1'b0;
        end else begin
            if (ph8 < 0) begin
                if (start8) begin
                    pend8 = 9'(a8) + 9'(b8) + 9'(cin8);
                    ph8 = 0;
                end
            end else begin
                ph8 = ph8 + 1;
                if (ph8 == 8) {mc8, ms8} = pend8;
                else if (ph8 == 9) ph8 = -1;
            end
            if (ph1 < 0) begin
                if (start1) begin
                    pend1 = 2'(a1) + 2'(b1) + 2'(cin1);
                    ph1 = 0;
                end
            end else begin
                ph1 = ph1 + 1;
                if (ph1 == 1) {mc1, ms1} = pend1;
                else if (ph1 == 2) ph1 = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (done8) dn8++;
        if (chk_en) begin
            chk("busy8", 32'(busy8), 32'(ph8 >= 0 && ph8 < 8));
            chk("done8", 32'(done8), 32'(ph8 == 8));
            chk("sum8",  32'(sum8),  32'(ms8));
            chk("cout8", 32'(cout8), 32'(mc8));
            chk("busy1", 32'(busy1), 32'(ph1 == 0));
            chk("done1", 32'(done1), 32'(ph1 == 1));
            chk("sum1",  32'(sum1),  32'(ms1));
            chk("cout1", 32'(cout1), 32'(mc1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        tick();
        start8 = 1'b0;
        repeat (9) tick();
    endtask

    int d0;

    initial begin
        repeat (2) tick();
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8",  32'(sum8),  32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Back-to-back with start held: second op only accepted once back in IDLE
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0;
        tick();
        chk("c1_busy_after_E0", 32'(busy8), 32'd1);
        a8 = 8'h01; b8 = 8'h01;
        repeat (9) tick();
        chk("c1_sum",  32'(sum8), 32'h8D);
        chk("c1_cout", 32'(cout8), 32'd0);
        chk("c1_model_sum", 32'(ms8), 32'h8D);
        chk("c3_busy_before_E10", 32'(busy8), 32'd0);
        tick();
        start8 = 1'b0;
        chk("c3_accepted_E10", 32'(busy8), 32'd1);
        chk("c3_sum_held", 32'(sum8), 32'h8D);
        repeat (9) tick();
        chk("c3_sum", 32'(sum8), 32'h02);

        op8(8'hFF, 8'h01, 1'b0);
        chk("c2a_sum", 32'(sum8), 32'h00);
        chk("c2a_cout", 32'(cout8), 32'd1);
        op8(8'hFF, 8'hFF, 1'b1);
        chk("c2b_sum", 32'(sum8), 32'hFF);
        chk("c2b_cout", 32'(cout8), 32'd1);
        chk("c2b_model_cout", 32'(mc8), 32'd1);

        // Start during SHIFT with altered operands must be ignored
        d0 = dn8;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h55;
        tick();
        start8 = 1'b0;
        repeat (6) tick();
        chk("c4_sum", 32'(sum8), 32'h30);
        chk("c4_cout", 32'(cout8), 32'd0);
        chk("c4_one_done", 32'(dn8 - d0), 32'd1);

        // Reset mid-operation aborts with no done pulse
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c5_busy", 32'(busy8), 32'd0);
        chk("c5_done", 32'(done8), 32'd0);
        chk("c5_sum",  32'(sum8),  32'd0);
        chk("c5_cout", 32'(cout8), 32'd0);
        d0 = dn8;
        repeat (10) tick();
        chk("c5_no_done", 32'(dn8 - d0), 32'd0);
        op8(8'h12, 8'h34, 1'b1);
        chk("c5_fresh_sum", 32'(sum8), 32'h47);

        // WIDTH=1
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("c6_busy1", 32'(busy1), 32'd1);
        tick();
        chk("c6_busy1_off", 32'(busy1), 32'd0);
        chk("c6_done1", 32'(done1), 32'd1);
        chk("c6_sum1", 32'(sum1), 32'd1);
        chk("c6_cout1", 32'(cout1), 32'd1);
        tick();

        // Random ops with ignored start noise during SHIFT/DONE
        for (int i = 0; i < 1000; i++) begin
            start8 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
            for (int k = 1; k <= 9; k++) begin
                start8 = 1'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                tick();
            end
        end
        start8 = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
